// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Bytes per I-cache line / queue entry.
    localparam int unsigned LINE_BYTES = 16;
    // Bit position of the line index within a byte address.
    localparam int unsigned LINE_LSB   = 4;
    // Bit position of the word offset within a byte address.
    localparam int unsigned OFF_LSB    = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue_ctrl.sv
// Instruction-fetch sequencer: issues line requests to the I-cache, pushes
// returned lines into the instruction queue, and turns redirects into a
// queue flush carrying the target line and its word offset.
module fetch_queue_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h0040_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_ic_req,
    output logic [ADDR_WIDTH-1:0] o_ic_addr,
    input  logic                  i_ic_valid,
    input  logic [DATA_WIDTH-1:0] i_ic_data,
    input  logic                  i_q_full,
    output logic                  o_q_wen,
    output logic                  o_q_flush,
    output logic [DATA_WIDTH-1:0] o_q_data,
    output logic [1:0]            o_q_off,
    output logic [ADDR_WIDTH-1:0] o_fetch_pc
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP  = ADDR_WIDTH'(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] RESET_LINE = RESET_PC & LINE_MASK;
    localparam logic [1:0]            RESET_OFF  = RESET_PC[LINE_LSB-1:OFF_LSB];

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            off_q;
    logic                  req_q;
    logic                  flush_pend_q;
    logic                  drop_pend_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  resp_use;
    logic                  resp_wen;
    logic                  hold_wen;
    logic                  resp_flush;

    // Byte-within-word bits of the redirect target carry no information.
    logic                  unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^i_redirect_pc[OFF_LSB-1:0];

    // Decode which response/hold events actually reach the queue this cycle.
    always_comb begin
        resp_use   = 1'b0;
        resp_wen   = 1'b0;
        resp_flush = 1'b0;
        hold_wen   = 1'b0;
        if (!i_rst && !i_redirect) begin
            resp_use   = (state_q == WAIT) && i_ic_valid && !drop_pend_q;
            resp_flush = resp_use && flush_pend_q;
            resp_wen   = resp_use && !flush_pend_q && !i_q_full;
            hold_wen   = (state_q == HOLD) && !i_q_full;
        end
    end

    // Queue-side outputs; data and offset are zero whenever nothing is written.
    always_comb begin
        o_q_wen   = resp_wen || hold_wen;
        o_q_flush = resp_flush;
        o_q_data  = '0;
        o_q_off   = 2'b00;
        if (resp_wen || resp_flush) begin
            o_q_data = i_ic_data;
        end else if (hold_wen) begin
            o_q_data = hold_q;
        end
        if (resp_flush) begin
            o_q_off = off_q;
        end
    end

    assign o_ic_req   = req_q;
    assign o_ic_addr  = addr_q;
    assign o_fetch_pc = fetch_pc_q;

    // Fetch FSM, fetch pointer and pending flush/drop bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_LINE;
            addr_q       <= RESET_LINE;
            off_q        <= RESET_OFF;
            req_q        <= 1'b0;
            flush_pend_q <= 1'b1;
            drop_pend_q  <= 1'b0;
        end else if (i_redirect) begin
            fetch_pc_q   <= i_redirect_pc & LINE_MASK;
            off_q        <= i_redirect_pc[LINE_LSB-1:OFF_LSB];
            flush_pend_q <= 1'b1;
            case (state_q)
                WAIT: begin
                    if (i_ic_valid) begin
                        // Response coincides with the redirect: it is stale, drop it now.
                        req_q       <= 1'b0;
                        drop_pend_q <= 1'b0;
                        state_q     <= FETCH;
                    end else begin
                        // Keep the outstanding request; its response will be dropped.
                        drop_pend_q <= 1'b1;
                    end
                end
                HOLD:    state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    req_q   <= 1'b1;
                    addr_q  <= fetch_pc_q;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (i_ic_valid) begin
                        req_q <= 1'b0;
                        if (drop_pend_q) begin
                            drop_pend_q <= 1'b0;
                            state_q     <= FETCH;
                        end else if (flush_pend_q) begin
                            flush_pend_q <= 1'b0;
                            fetch_pc_q   <= fetch_pc_q + LINE_STEP;
                            state_q      <= FETCH;
                        end else if (!i_q_full) begin
                            fetch_pc_q <= fetch_pc_q + LINE_STEP;
                            state_q    <= FETCH;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!i_q_full) begin
                        fetch_pc_q <= fetch_pc_q + LINE_STEP;
                        state_q    <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Capture a returned line that could not be written because the queue was full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q <= '0;
        end else if (resp_use && !flush_pend_q && i_q_full) begin
            hold_q <= i_ic_data;
        end
    end

endmodule : fetch_queue_ctrl

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: reset, streaming, backpressure,
// redirect corner cases and mid-transaction reset.
module tb_fetch_queue_ctrl;

    logic         i_clk;
    logic         i_rst;
    logic         i_redirect;
    logic [31:0]  i_redirect_pc;
    logic         o_ic_req;
    logic [31:0]  o_ic_addr;
    logic         i_ic_valid;
    logic [127:0] i_ic_data;
    logic         i_q_full;
    logic         o_q_wen;
    logic         o_q_flush;
    logic [127:0] o_q_data;
    logic [1:0]   o_q_off;
    logic [31:0]  o_fetch_pc;

    int compared;
    int mismatched;

    fetch_queue_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (128),
        .RESET_PC   (32'h0040_0008)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_ic_req      (o_ic_req),
        .o_ic_addr     (o_ic_addr),
        .i_ic_valid    (i_ic_valid),
        .i_ic_data     (i_ic_data),
        .i_q_full      (i_q_full),
        .o_q_wen       (o_q_wen),
        .o_q_flush     (o_q_flush),
        .o_q_data      (o_q_data),
        .o_q_off       (o_q_off),
        .o_fetch_pc    (o_fetch_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Write enable and flush must never coincide.
    always @(negedge i_clk) begin
        if (o_q_wen === 1'b1 && o_q_flush === 1'b1) begin
            mismatched++;
            $display("FAIL wen_and_flush: got both 1 required at most one at %0t", $time);
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (o_ic_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        cyc(); cyc();
        compared++; if (o_ic_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b required 0", o_ic_req); end
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL rst_wen_flush: got %b%b required 00", o_q_wen, o_q_flush); end
        compared++; if (o_q_data !== 128'd0 || o_q_off !== 2'd0) begin mismatched++; $display("FAIL rst_data_off: got %h/%0d required 0/0", o_q_data, o_q_off); end
        compared++; if (o_fetch_pc !== 32'h0040_0000) begin mismatched++; $display("FAIL rst_fetch_pc: got %h required 00400000", o_fetch_pc); end
        i_rst = 1'b0;
        cyc();
        compared++; if (o_ic_req !== 1'b1 || o_ic_addr !== 32'h0040_0000) begin mismatched++; $display("FAIL t1_first_req: got %b/%h required 1/00400000", o_ic_req, o_ic_addr); end
        cyc();
        compared++; if (o_ic_req !== 1'b1 || o_ic_addr !== 32'h0040_0000) begin mismatched++; $display("FAIL t1_req_hold: got %b/%h required 1/00400000", o_ic_req, o_ic_addr); end
        i_ic_valid = 1'b1; i_ic_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        #1;
        compared++; if (o_q_flush !== 1'b1 || o_q_wen !== 1'b0 || o_q_off !== 2'd2) begin mismatched++; $display("FAIL t1_flush: got f%b w%b off%0d required f1 w0 off2", o_q_flush, o_q_wen, o_q_off); end
        compared++; if (o_q_data !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin mismatched++; $display("FAIL t1_flush_data: got %h", o_q_data); end
        cyc();
        i_ic_valid = 1'b0;
        compared++; if (o_ic_req !== 1'b0 || o_fetch_pc !== 32'h0040_0010) begin mismatched++; $display("FAIL t1_after: got %b/%h required 0/00400010", o_ic_req, o_fetch_pc); end
        cyc();
        compared++; if (o_ic_req !== 1'b1 || o_ic_addr !== 32'h0040_0010) begin mismatched++; $display("FAIL t1_next_req: got %b/%h required 1/00400010", o_ic_req, o_ic_addr); end
    endtask

    task automatic test_streaming();
        bit ok;
        logic [127:0] d;
        logic [31:0]  a;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0040_0010 + 32'(16 * i);
            d = {4{32'hA000_0000 + 32'(i)}};
            wait_req(ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL t2_req_timeout: got no req required req %0d", i); end
            compared++; if (o_ic_addr !== a) begin mismatched++; $display("FAIL t2_addr: got %h required %h", o_ic_addr, a); end
            cyc();
            i_ic_valid = 1'b1; i_ic_data = d; i_q_full = 1'b0;
            #1;
            compared++; if (o_q_wen !== 1'b1 || o_q_flush !== 1'b0 || o_q_data !== d) begin mismatched++; $display("FAIL t2_write: got w%b f%b %h required w1 f0 %h", o_q_wen, o_q_flush, o_q_data, d); end
            cyc();
            i_ic_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0050) begin mismatched++; $display("FAIL t3_req: got %b/%h required 1/00400050", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF; i_q_full = 1'b1;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL t3_no_write_full: got w%b f%b required w0 f0", o_q_wen, o_q_flush); end
        cyc();
        i_ic_valid = 1'b0; i_ic_data = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            compared++; if (o_ic_req !== 1'b0 || o_q_wen !== 1'b0) begin mismatched++; $display("FAIL t3_hold_idle: got req%b w%b required req0 w0", o_ic_req, o_q_wen); end
            cyc();
        end
        i_q_full = 1'b0;
        #1;
        compared++; if (o_q_wen !== 1'b1 || o_q_data !== 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF) begin mismatched++; $display("FAIL t3_hold_write: got w%b %h required w1 held line", o_q_wen, o_q_data); end
        cyc();
        compared++; if (o_fetch_pc !== 32'h0040_0060 || o_q_wen !== 1'b0) begin mismatched++; $display("FAIL t3_after: got %h w%b required 00400060 w0", o_fetch_pc, o_q_wen); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0060) begin mismatched++; $display("FAIL t4_req: got %b/%h required 1/00400060", ok, o_ic_addr); end
        i_redirect = 1'b1; i_redirect_pc = 32'h0040_0124;
        cyc();
        i_redirect = 1'b0;
        compared++; if (o_ic_req !== 1'b1 || o_ic_addr !== 32'h0040_0060 || o_fetch_pc !== 32'h0040_0120) begin mismatched++; $display("FAIL t4_keep_req: got %b/%h pc %h required 1/00400060 pc 00400120", o_ic_req, o_ic_addr, o_fetch_pc); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'hDEAD;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL t4_stale_drop: got w%b f%b required w0 f0", o_q_wen, o_q_flush); end
        cyc();
        i_ic_valid = 1'b0;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0120) begin mismatched++; $display("FAIL t4_target_req: got %b/%h required 1/00400120", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'h0120_0120;
        #1;
        compared++; if (o_q_flush !== 1'b1 || o_q_wen !== 1'b0 || o_q_off !== 2'd1 || o_q_data !== 128'h0120_0120) begin mismatched++; $display("FAIL t4_flush: got f%b w%b off%0d %h required f1 w0 off1 01200120", o_q_flush, o_q_wen, o_q_off, o_q_data); end
        cyc();
        i_ic_valid = 1'b0;
    endtask

    task automatic test_redirect_same_cycle_and_hold();
        bit ok;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0130) begin mismatched++; $display("FAIL t5_req: got %b/%h required 1/00400130", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'hBAD1; i_redirect = 1'b1; i_redirect_pc = 32'h0040_0308;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL t5_same_cycle_drop: got w%b f%b required w0 f0", o_q_wen, o_q_flush); end
        cyc();
        i_ic_valid = 1'b0; i_redirect = 1'b0;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0300) begin mismatched++; $display("FAIL t5_target_req: got %b/%h required 1/00400300", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'h0300;
        #1;
        compared++; if (o_q_flush !== 1'b1 || o_q_off !== 2'd2 || o_q_data !== 128'h0300) begin mismatched++; $display("FAIL t5_flush: got f%b off%0d %h required f1 off2 0300", o_q_flush, o_q_off, o_q_data); end
        cyc();
        i_ic_valid = 1'b0;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0310) begin mismatched++; $display("FAIL t5_req2: got %b/%h required 1/00400310", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'hBAD2; i_q_full = 1'b1;
        cyc();
        i_ic_valid = 1'b0;
        cyc();
        i_q_full = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0040_0404;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_ic_req !== 1'b0) begin mismatched++; $display("FAIL t5_hold_redirect: got w%b req%b required w0 req0", o_q_wen, o_ic_req); end
        cyc();
        i_redirect = 1'b0;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0400) begin mismatched++; $display("FAIL t5_target_req2: got %b/%h required 1/00400400", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'h0400;
        #1;
        compared++; if (o_q_flush !== 1'b1 || o_q_wen !== 1'b0 || o_q_off !== 2'd1 || o_q_data !== 128'h0400) begin mismatched++; $display("FAIL t5_flush2: got f%b w%b off%0d %h required f1 w0 off1 0400", o_q_flush, o_q_wen, o_q_off, o_q_data); end
        cyc();
        i_ic_valid = 1'b0;
    endtask

    task automatic test_back_to_back_redirect();
        bit ok;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0040_0410) begin mismatched++; $display("FAIL t6_req: got %b/%h required 1/00400410", ok, o_ic_addr); end
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
        cyc();
        i_redirect = 1'b0;
        cyc();
        i_redirect = 1'b1; i_redirect_pc = 32'h0000_0208;
        cyc();
        i_redirect = 1'b0;
        compared++; if (o_fetch_pc !== 32'h0000_0200 || o_ic_addr !== 32'h0040_0410) begin mismatched++; $display("FAIL t6_last_target: got pc %h addr %h required 00000200/00400410", o_fetch_pc, o_ic_addr); end
        i_ic_valid = 1'b1; i_ic_data = 128'hBAD3;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL t6_stale_drop: got w%b f%b required w0 f0", o_q_wen, o_q_flush); end
        cyc();
        i_ic_valid = 1'b0;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0000_0200) begin mismatched++; $display("FAIL t6_target_req: got %b/%h required 1/00000200", ok, o_ic_addr); end
        cyc();
        i_ic_valid = 1'b1; i_ic_data = 128'h0200;
        #1;
        compared++; if (o_q_flush !== 1'b1 || o_q_off !== 2'd2 || o_q_data !== 128'h0200) begin mismatched++; $display("FAIL t6_flush: got f%b off%0d %h required f1 off2 0200", o_q_flush, o_q_off, o_q_data); end
        cyc();
        i_ic_valid = 1'b0;
    endtask

    task automatic test_reset_mid_transaction();
        bit ok;
        wait_req(ok);
        compared++; if (!ok || o_ic_addr !== 32'h0000_0210) begin mismatched++; $display("FAIL t7_req: got %b/%h required 1/00000210", ok, o_ic_addr); end
        i_rst = 1'b1; i_ic_valid = 1'b1; i_ic_data = 128'hBAD4;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0) begin mismatched++; $display("FAIL t7_no_write_in_reset: got w%b f%b required w0 f0", o_q_wen, o_q_flush); end
        cyc();
        i_ic_valid = 1'b0;
        cyc();
        i_rst = 1'b0;
        i_ic_valid = 1'b1;
        #1;
        compared++; if (o_q_wen !== 1'b0 || o_q_flush !== 1'b0 || o_ic_req !== 1'b0) begin mismatched++; $display("FAIL t7_late_valid: got w%b f%b req%b required 000", o_q_wen, o_q_flush, o_ic_req); end
        cyc();
        i_ic_valid = 1'b0;
        compared++; if (o_ic_req !== 1'b1 || o_ic_addr !== 32'h0040_0000) begin mismatched++; $display("FAIL t7_restart: got %b/%h required 1/00400000", o_ic_req, o_ic_addr); end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ic_valid    = 1'b0;
        i_ic_data     = '0;
        i_q_full      = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle_and_hold();
        test_back_to_back_redirect();
        test_reset_mid_transaction();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fetch_queue_ctrl
